// File: rtl/mdr_sequencer_pkg.sv
// pkg_system_mdr: shared MDR op codes, widths, sequencer states and iteration counts.
package pkg_system_mdr;
    localparam int DW  = 16;
    localparam int DW2 = DW / 2;
    typedef enum logic [1:0] {MULT = 2'b00, DIV = 2'b01, ROOT = 2'b10} op_t;
    typedef enum logic [2:0] {IDLE, INIT, RUN, DONE, ERR} st_mdr_seq_state;
    // ROOT resolves two result bits per iteration, so it needs half the passes.
    function automatic int n_iter(input logic [1:0] op, input int dw = DW);
        return (op == ROOT) ? dw / 2 : dw;
    endfunction
endpackage

// File: rtl/mdr_iter_cnt.sv
// mdr_iter_cnt: loadable down-counter with zero flag for the MDR sequencer.
module mdr_iter_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] ld_val,
    output logic [CW-1:0] value,
    output logic          zero
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) value <= '0;
        else if (load) value <= ld_val;
        else if (dec) value <= value - CW'(1);
    assign zero = (value == '0);
endmodule

// File: rtl/mdr_sequencer.sv
// mdr_sequencer: start/init/enable/done control for the MDR datapath.
// Define MDR_DIV0_CHECK_EN to reject DIV with a zero divisor through ERR.
module mdr_sequencer
    import pkg_system_mdr::*;
#(
    parameter int DW = 16,
    parameter int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [1:0]    i_op,
    input  logic [DW-1:0] i_divisor,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_init,
    output logic          o_enable,
    output logic [1:0]    o_op,
    output logic [CW-1:0] o_iter,
    output logic          o_last,
    output logic          o_done,
    output logic          o_err
);
    st_mdr_seq_state state, nxt;
    logic [1:0] op_q;
    logic bad, load, dec, zero;
`ifdef MDR_DIV0_CHECK_EN
    assign bad = (i_op == 2'b11) || (i_op == DIV && i_divisor == '0);
`else
    logic unused_div;
    assign unused_div = ^i_divisor;
    assign bad = (i_op == 2'b11);
`endif
    assign load = (state == IDLE) && i_start && !bad;
    // Hold at zero after the last pass so o_iter rests at 0 rather than wrapping.
    assign dec = (state == RUN) && !zero;
    mdr_iter_cnt #(.CW(CW)) u_cnt (
        .clk(clk), .rst(rst), .load(load), .dec(dec),
        .ld_val(CW'(n_iter(i_op, DW) - 1)), .value(o_iter), .zero(zero)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            op_q  <= MULT;
        end else begin
            state <= nxt;
            if (load) op_q <= i_op;
        end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = !i_start ? IDLE : bad ? ERR : INIT;
            INIT:      nxt = RUN;
            RUN:       nxt = zero ? DONE : RUN;
            default:   nxt = IDLE;
        endcase
    end
    assign o_ready  = (state == IDLE);
    assign o_busy   = (state != IDLE);
    assign o_init   = (state == INIT);
    assign o_enable = (state == RUN);
    assign o_last   = (state == RUN) && zero;
    assign o_done   = (state == DONE) || (state == ERR);
    assign o_err    = (state == ERR);
    assign o_op     = op_q;
endmodule

// File: tb/tb_mdr_sequencer.sv
// tb_mdr_sequencer: directed checks of mdr_sequencer timing, errors, restarts and reset.
module tb_mdr_sequencer;
    localparam int DW = 16;
    localparam int CW = 4;
    logic clk = 0, rst = 0, i_start = 0;
    logic [1:0] i_op = 0;
    logic [DW-1:0] i_divisor = 0;
    logic o_ready, o_busy, o_init, o_enable, o_last, o_done, o_err;
    logic [1:0] o_op;
    logic [CW-1:0] o_iter;
    int checks = 0, errors = 0;

    mdr_sequencer #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_divisor(i_divisor),
        .o_ready(o_ready), .o_busy(o_busy), .o_init(o_init), .o_enable(o_enable),
        .o_op(o_op), .o_iter(o_iter), .o_last(o_last), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in cycle 0 and follow the full n-iteration sequence through cycle n+3.
    task automatic run_seq(input string tag, input logic [1:0] op, input logic [DW-1:0] dv, input int n);
        int en_cnt = 0;
        i_start = 1; i_op = op; i_divisor = dv;
        tick();
        i_start = 0; i_op = 2'b11; i_divisor = 16'hffff;
        check({tag, " init c1"}, {o_init, o_enable, o_busy, o_ready}, 4'b1010);
        check({tag, " op c1"}, o_op, op);
        for (int c = 2; c <= n + 1; c++) begin
            tick();
            en_cnt += o_enable;
            check({tag, " iter"}, o_iter, n + 1 - c);
            check({tag, " last"}, o_last, c == n + 1);
        end
        check({tag, " enables"}, en_cnt, n);
        tick();
        check({tag, " done"}, {o_done, o_err, o_enable, o_init}, 4'b1000);
        check({tag, " op at done"}, o_op, op);
        tick();
        check({tag, " ready"}, {o_ready, o_busy, o_done}, 3'b100);
    endtask

    initial begin
        int dn, cyc;
        #3;
        check("reset outputs", {o_ready, o_busy, o_init, o_enable, o_last, o_done, o_err}, 7'b1000000);
        check("reset op/iter", {o_op, o_iter}, 6'b0);
        #4 rst = 1;
        tick();
        check("idle no start", {o_ready, o_busy}, 2'b10);

        run_seq("MULT", 2'b00, 16'h1234, 16);
        run_seq("ROOT", 2'b10, 16'h0000, 8);

`ifdef MDR_DIV0_CHECK_EN
        i_start = 1; i_op = 2'b01; i_divisor = 0;
        tick();
        i_start = 0;
        check("div0 err c1", {o_done, o_err, o_init, o_enable}, 4'b1100);
        tick();
        check("div0 ready c2", {o_ready, o_init, o_done}, 3'b100);
`else
        run_seq("DIV0", 2'b01, 16'h0000, 16);
`endif

        i_start = 1; i_op = 2'b11;
        tick();
        i_start = 0; i_op = 0;
        check("badop err c1", {o_done, o_err, o_init, o_enable, o_busy}, 5'b11001);
        tick();
        check("badop ready c2", {o_ready, o_done, o_err, o_enable}, 4'b1000);

        // DIV with ignored restarts at cycle 5 and at the DONE cycle 18
        i_start = 1; i_op = 2'b01; i_divisor = 16'd5;
        tick();
        i_start = 0;
        dn = 0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 3) i_op = 2'b10;
            i_start = (c == 5 || c == 18);
            if (c == 18) i_op = 2'b00;
            dn += o_done;
            if (c == 18) check("restart done c18", {o_done, o_err, o_op}, 4'b1001);
            tick();
        end
        i_start = 0;
        check("restart ignored c19", {o_ready, o_init, o_done}, 3'b100);
        check("restart one done", dn, 1);
        i_start = 1; i_op = 2'b00;
        tick();
        i_start = 0;
        check("new start init c20", {o_init, o_op}, 3'b100);
        cyc = 0;
        while (!o_ready && cyc < 40) begin tick(); cyc++; end
        check("drain to idle", o_ready, 1'b1);

        // Asynchronous reset mid-run
        i_start = 1; i_op = 2'b00;
        tick();
        i_start = 0;
        for (int c = 1; c < 7; c++) tick();
        check("pre-reset enable c7", o_enable, 1'b1);
        #2 rst = 0;
        #1;
        check("async reset outputs", {o_ready, o_busy, o_enable, o_last, o_done, o_err}, 6'b100000);
        check("async reset op/iter", {o_op, o_iter}, 6'b0);
        @(negedge clk) rst = 1;
        dn = 0;
        for (int c = 0; c < 25; c++) begin tick(); dn += o_done; end
        check("no done after reset", dn, 0);
        check("idle after reset", o_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
- Control stage directly upstream of the remainder/accumulator register in the multiply/divide/root (MDR) datapath.
- Accepts a start request with an operation code and divisor, then drives the one-cycle init pulse and the per-iteration enable train for the selected operation.
- Reports last iteration, done and error.
- Owns all iteration counting. Downstream register and ALU stages are purely enable-driven.

Parameters:
- DW, 16, operand width in bits. Must be even and at least 4.
- CW, $clog2(DW), iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  request pulse; sampled only while o_ready=1.
- i_op  in  2  operation code: MULT, DIV or ROOT from the package. The fourth code is invalid.
- i_divisor  in  DW  divisor operand, sampled with i_start; used only for DIV.
- o_ready  out  1  high only in IDLE.
- o_busy  out  1  high in INIT, RUN, DONE and ERR.
- o_init  out  1  one-cycle load strobe to the remainder and operand registers.
- o_enable  out  1  iteration strobe, high for every RUN cycle.
- o_op  out  2  latched op; stable from INIT through DONE.
- o_iter  out  CW  iterations remaining minus 1; counts down during RUN.
- o_last  out  1  high on the final RUN cycle; equals o_enable AND (o_iter==0).
- o_done  out  1  one-cycle completion pulse, including on error.
- o_err  out  1  qualifies o_done; high only in the ERR state.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low.
- Reset values:
  - state=IDLE, o_ready=1.
  - o_busy, o_init, o_enable, o_last, o_done and o_err are 0.
  - o_op=MULT, o_iter=0.
- States: IDLE, INIT, RUN, DONE, ERR. Outputs are registered or decoded from the registered state; there is no combinational path from i_* to outputs.
- IDLE:
  - i_start=1 with a valid op goes to INIT. On that edge, op_q<=i_op and the counter loads N-1.
  - i_start=1 with op=2'b11 goes to ERR.
  - i_start=1 with DIV and i_divisor==0 goes to ERR, only if the optional feature is compiled in.
  - i_start=0 stays in IDLE.
- INIT: o_init=1 for exactly one cycle, then RUN.
- RUN:
  - o_enable=1 every cycle.
  - The counter decrements each cycle; at o_iter==0, o_last=1 and the next state is DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- ERR: o_done=1 and o_err=1 for one cycle, then IDLE. No init or enable is issued.
- Iteration count N:
  - MULT = DW.
  - DIV = DW.
  - ROOT = DW/2, two result bits per iteration.
- Latency, with the start sampled in cycle 0:
  - INIT in cycle 1.
  - RUN in cycles 2 to N+1.
  - o_done in cycle N+2.
  - Next start is accepted in cycle N+3.
- i_start while o_ready=0 is ignored, not queued. This includes the DONE cycle.
- i_op and i_divisor changes after acceptance have no effect.
- Reset asserted in any state returns all outputs to reset values immediately. No done pulse is issued.

Optional Feature:
- Macro: MDR_DIV0_CHECK_EN.
- Defined: DIV with i_divisor==0 at start goes to ERR. Response is o_done=o_err=1 in cycle 1 and no o_init.
- Undefined: i_divisor is unused. DIV by zero runs a normal DW-iteration sequence; the datapath result is don't-care. ERR is reachable only via the invalid op.

Decomposition:
- Package pkg_system_mdr:
  - op enum (MULT, DIV, ROOT) and DW/DW2 constants, reused.
  - New typedef st_mdr_seq_state enum for the five states.
  - Function n_iter(op) returning N.
- Sub-module mdr_iter_cnt: loadable down-counter with load, dec, value and zero outputs. The FSM stays in mdr_sequencer.

Test Plan (DW=16):
- MULT start in cycle 0 -> o_init cycle 1; o_enable cycles 2-17; o_iter 15 down to 0; o_last cycle 17; o_done cycle 18 with o_err=0; o_ready cycle 19.
- ROOT start -> 8 enable cycles (2-9); o_last cycle 9; o_done cycle 10; o_op=ROOT held through cycle 10.
- DIV, divisor=0:
  - With MDR_DIV0_CHECK_EN, o_done=o_err=1 in cycle 1, o_init never asserted.
  - Without it, normal 16-iteration run with done in cycle 18.
- op=2'b11 -> ERR: o_done=o_err=1 cycle 1; zero enables; ready cycle 2.
- Re-start is ignored:
  - DIV start, then i_start pulses in cycle 5 and in the DONE cycle (cycle 18) are ignored. Exactly one done is produced and the FSM returns to IDLE.
  - A new start in cycle 19 yields init in cycle 20.
- Reset mid-run: MULT start, rst low in cycle 7 -> o_enable=0 and o_ready=1 asynchronously. No o_done follows after rst is released.
